// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the iterative AES-128 encryption core.
//   BLOCK_W / KEY_W : block and key widths (128 bits, FIPS-197 byte order,
//                     byte 0 in bits [127:120]).
//   aes_state_e     : control FSM states IDLE / BUSY / DONE.
//   xtime, gf_mul   : GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1.
//   sbox            : forward S-box, computed as multiplicative inverse
//                     followed by the affine transform.
//   rcon            : round-constant table for key expansion rounds 1..10.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is x^254 (which maps 0 to 0 as the S-box definition needs).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round -- one combinational AES-128 encryption round plus the matching
// key-expansion step.
//   state_i : state after the previous AddRoundKey
//   rkey_i  : round key used by the previous AddRoundKey
//   rcon_i  : round constant for the key produced here
//   final_i : 1 = last round, MixColumns is skipped
//   state_o : state after this round's AddRoundKey
//   rkey_o  : round key produced (and applied) by this round
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [KEY_W-1:0]   rkey_i,
  input  logic [7:0]         rcon_i,
  input  logic               final_i,
  output logic [BLOCK_W-1:0] state_o,
  output logic [KEY_W-1:0]   rkey_o
);

  // Next round key: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon, then ripple.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, tmp, n0, n1, n2, n3;
    w0  = rkey_i[127:96];
    w1  = rkey_i[95:64];
    w2  = rkey_i[63:32];
    w3  = rkey_i[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
          {rcon_i, 24'h000000};
    n0  = w0 ^ tmp;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    rkey_o = {n0, n1, n2, n3};
  end

  // SubBytes, ShiftRows, MixColumns (bypassed on the final round), AddRoundKey.
  always_comb begin
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    logic [7:0] a0, a1, a2, a3;
    // Byte index r+4c holds row r of column c; ShiftRows pulls from column c+r.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r + 4*c] = sbox(state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    state_o = {BLOCK_W{1'b0}};
    for (int i = 0; i < 16; i++) begin
      state_o[127 - 8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rkey_o[127 - 8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core -- iterative AES-128 encryption core, ROUNDS_PER_CYCLE rounds
// per clock (1, 2, 5 or 10), valid/ready handshakes on both sides.
// Optional macro AES_CBC_EN adds CBC chaining (iv_in, new_chain_in and an
// internal chain register); without it the core is pure ECB.
//   clk, rst_n     : clock, synchronous active-low reset
//   valid_in/ready_in, plaintext_in, key_in : input block handshake
//   iv_in, new_chain_in                     : CBC chain control (AES_CBC_EN)
//   valid_out/ready_out, ciphertext_out     : result handshake
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [BLOCK_W-1:0] plaintext_in,
  input  logic [KEY_W-1:0]   key_in,
`ifdef AES_CBC_EN
  input  logic [BLOCK_W-1:0] iv_in,
  input  logic               new_chain_in,
`endif
  input  logic               ready_out,
  output logic               valid_out,
  output logic [BLOCK_W-1:0] ciphertext_out
);

  localparam int NUM_ROUNDS = 10;
  localparam int CYCLES     = NUM_ROUNDS / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  aes_state_e         state_q, state_d;
  logic               ready_q, ready_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BLOCK_W-1:0] st_q, st_d;
  logic [KEY_W-1:0]   rk_q, rk_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [BLOCK_W-1:0] chain_s;
  logic [BLOCK_W-1:0] last_st_s;
  logic [KEY_W-1:0]   last_rk_s;

`ifdef AES_CBC_EN
  logic [BLOCK_W-1:0] chain_q, chain_d;
  assign chain_s = new_chain_in ? iv_in : chain_q;
`else
  assign chain_s = {BLOCK_W{1'b0}};
`endif

  // Round chain; each stage knows its absolute round number for Rcon and
  // for the final-round flag.
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [BLOCK_W-1:0] st_in_s, st_out_s;
    logic [KEY_W-1:0]   rk_in_s, rk_out_s;
    logic [3:0]         rnd_s;
    if (g == 0) begin : g_first
      assign st_in_s = st_q;
      assign rk_in_s = rk_q;
    end else begin : g_next
      assign st_in_s = g_round[g-1].st_out_s;
      assign rk_in_s = g_round[g-1].rk_out_s;
    end
    assign rnd_s = cnt_q * 4'(ROUNDS_PER_CYCLE) + 4'(g + 1);
    aes_round u_round (
      .state_i (st_in_s),
      .rkey_i  (rk_in_s),
      .rcon_i  (rcon(rnd_s)),
      .final_i (rnd_s == 4'(NUM_ROUNDS)),
      .state_o (st_out_s),
      .rkey_o  (rk_out_s)
    );
  end
  assign last_st_s = g_round[ROUNDS_PER_CYCLE-1].st_out_s;
  assign last_rk_s = g_round[ROUNDS_PER_CYCLE-1].rk_out_s;

  // Next-state logic and datapath load selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
`ifdef AES_CBC_EN
    chain_d = chain_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          state_d = BUSY;
          st_d    = plaintext_in ^ key_in ^ chain_s;
          rk_d    = key_in;
          cnt_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        st_d = last_st_s;
        rk_d = last_rk_s;
        if (cnt_q == 4'(CYCLES - 1)) begin
          state_d = DONE;
          ct_d    = last_st_s;
`ifdef AES_CBC_EN
          chain_d = last_st_s;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (ready_out) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ready_in is registered: it rises the cycle the FSM settles in IDLE,
    // which also keeps it low for the cycle following a reset edge.
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      cnt_q   <= 4'd0;
      st_q    <= {BLOCK_W{1'b0}};
      rk_q    <= {KEY_W{1'b0}};
      ct_q    <= {BLOCK_W{1'b0}};
`ifdef AES_CBC_EN
      chain_q <= {BLOCK_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
`ifdef AES_CBC_EN
      chain_q <= chain_d;
`endif
    end
  end

  assign ready_in       = ready_q;
  assign valid_out      = (state_q == DONE);
  assign ciphertext_out = ct_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed self-checking bench for aes_iter_core. Four instances run side by
// side (1, 2, 5 and 10 rounds per cycle); instance 0 carries the detailed
// handshake, backpressure and reset checks, the others always accept results.
module tb_aes_iter_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] plaintext_in;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic         new_chain_in;
  logic         rdy_a  [4];
  logic         vout_a [4];
  logic [127:0] ct_a   [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    aes_iter_core #(
      .ROUNDS_PER_CYCLE((i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 5 : 10)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .ready_in       (rdy_a[i]),
      .plaintext_in   (plaintext_in),
      .key_in         (key_in),
`ifdef AES_CBC_EN
      .iv_in          (iv_in),
      .new_chain_in   (new_chain_in),
`endif
      .ready_out      ((i == 0) ? ready_out : 1'b1),
      .valid_out      (vout_a[i]),
      .ciphertext_out (ct_a[i])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Submit one block to instance 0 (must be ready, ready_out=1), wait for the
  // result with a bound, then let the output handshake complete.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output int lat);
    plaintext_in = pt;
    key_in       = key;
    valid_in     = 1'b1;
    step();
    valid_in = 1'b0;
    lat = 0;
    while (lat < 20 && vout_a[0] !== 1'b1) begin
      step();
      lat++;
    end
    ct = ct_a[0];
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct;
    int           lat;
    int           first [4];
    logic [127:0] ct_first [4];
    int           exp_cyc [4];
    int           hs, dwell, tfirst;

    exp_cyc = '{10, 5, 2, 1};
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    plaintext_in = 128'h0; key_in = 128'h0; iv_in = 128'h0; new_chain_in = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_ready_in", 128'(rdy_a[0]), 128'h0);
    chk("rst_valid_out", 128'(vout_a[0]), 128'h0);
    chk("rst_ct", ct_a[0], 128'h0);
    rst_n = 1'b1;
    step();
    chk("release_ready_in", 128'(rdy_a[0]), 128'h1);

    // FIPS-197 C.1 on all four configurations, latency measured per instance
    plaintext_in = C1_PT; key_in = C1_KEY; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("busy_ready_in", 128'(rdy_a[0]), 128'h0);
    for (int i = 0; i < 4; i++) begin
      first[i] = 0;
      ct_first[i] = 128'h0;
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (vout_a[i] === 1'b1 && first[i] == 0) begin
          first[i] = k;
          ct_first[i] = ct_a[i];
        end
      end
      if (k == 11) chk("ready_after_handshake", 128'(rdy_a[0]), 128'h1);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c1_latency_%0d", i), 128'(first[i]), 128'(exp_cyc[i]));
      chk($sformatf("c1_ct_%0d", i), ct_first[i], C1_CT);
    end

    // FIPS-197 B with 7 cycles of backpressure
    ready_out = 1'b0;
    plaintext_in = B_PT; key_in = B_KEY; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    lat = 0;
    while (lat < 20 && vout_a[0] !== 1'b1) begin
      step();
      lat++;
    end
    chk("b_latency", 128'(lat), 128'd10);
    chk("b_ct", ct_a[0], B_CT);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("bp_valid_out", 128'(vout_a[0]), 128'h1);
      chk("bp_ct", ct_a[0], B_CT);
      chk("bp_ready_in", 128'(rdy_a[0]), 128'h0);
    end
    ready_out = 1'b1;
    step();
    chk("bp_release_valid_out", 128'(vout_a[0]), 128'h0);
    chk("idle_ct_hold", ct_a[0], B_CT);

`ifdef AES_CBC_EN
    // SP800-38A F.2.1 CBC chain
    iv_in = 128'h000102030405060708090a0b0c0d0e0f;
    new_chain_in = 1'b1;
    run_block(128'h6bc1bee22e409f96e93d7e117393172a, B_KEY, ct, lat);
    chk("cbc_ct1", ct, 128'h7649abac8119b246cee98e9b12e9197d);
    new_chain_in = 1'b0;
    run_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, B_KEY, ct, lat);
    chk("cbc_ct2", ct, 128'h5086cb9b507219ee95db113a917678b2);
    iv_in = 128'h0;
    new_chain_in = 1'b1;
`endif

    // Reset while BUSY with round counter at 4
    plaintext_in = C1_PT; key_in = C1_KEY; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("midrst_valid_out", 128'(vout_a[0]), 128'h0);
    chk("midrst_ready_in", 128'(rdy_a[0]), 128'h0);
    chk("midrst_ct", ct_a[0], 128'h0);
    rst_n = 1'b1;
    step();
    chk("midrst_release_ready_in", 128'(rdy_a[0]), 128'h1);
    run_block(C1_PT, C1_KEY, ct, lat);
    chk("midrst_c1_latency", 128'(lat), 128'd10);
    chk("midrst_c1_ct", ct, C1_CT);

    // valid_in toggling with differing data through BUSY and DONE
    ready_out = 1'b0;
    plaintext_in = C1_PT; key_in = C1_KEY; valid_in = 1'b1;
    step();
    hs = 0; dwell = 0; tfirst = 0; ct = 128'h0;
    for (int k = 1; k <= 40; k++) begin
      if (hs == 0) begin
        valid_in = ~valid_in;
        plaintext_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (vout_a[0] === 1'b1) begin
        if (tfirst == 0) begin
          tfirst = k;
          ct = ct_a[0];
        end
        dwell++;
        ready_out = (dwell >= 3);
        if (ready_out) hs++;
      end else begin
        ready_out = 1'b0;
      end
    end
    chk("toggle_latency", 128'(tfirst), 128'd10);
    chk("toggle_ct", ct, C1_CT);
    chk("toggle_handshakes", 128'(hs), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving the number of AES-128 rounds evaluated per clock; legal values 1, 2, 5, 10; any other value is an elaboration error.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, as a derived localparam only (not overridable); CYCLES = NUM_ROUNDS / ROUNDS_PER_CYCLE.
REQ-003 SHALL have exactly one clock and a synchronous, active-low reset:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- valid_in  input  1  input block valid
- ready_in  output  1  core can accept a block
- plaintext_in  input  128  plaintext block, FIPS-197 byte order
- key_in  input  128  cipher key
- iv_in  input  128  CBC initialisation vector (AES_CBC_EN only)
- new_chain_in  input  1  1 = start a new CBC chain using iv_in (AES_CBC_EN only)
- ready_out  input  1  consumer can accept the result
- valid_out  output  1  ciphertext_out valid
- ciphertext_out  output  128  ciphertext block

Function
REQ-004 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-005 ready_in SHALL be 1 only in IDLE; ready_in is a decode of the state register, not a combinational path from any input.
REQ-006 On valid_in && ready_in at a rising edge, SHALL capture key_in, load state = plaintext_in ^ key_in (round 0 AddRoundKey; with CBC also ^ chain value), clear the round counter to 0 and go to BUSY.
REQ-007 In BUSY, SHALL apply ROUNDS_PER_CYCLE rounds and the matching round-key expansion steps per cycle; round 10 omits MixColumns.
REQ-008 The round counter SHALL count 0..CYCLES-1 without wrap; after the edge where the counter equals CYCLES-1, SHALL go to DONE with the result registered.
REQ-009 valid_out SHALL be 1 exactly while in DONE; first assertion is CYCLES edges after the acceptance edge (10 cycles at ROUNDS_PER_CYCLE=1, 1 cycle at 10).
REQ-010 In DONE, ciphertext_out SHALL stay stable while ready_out=0 (backpressure); on ready_out=1, SHALL go to IDLE at that edge.
REQ-011 SHALL not accept a new block in the cycle that completes an output handshake; peak throughput is one block per CYCLES+2 cycles.
REQ-012 valid_in, plaintext_in and key_in SHALL be ignored in BUSY and DONE; in those states the captured key and state SHALL not change except by round processing.
REQ-013 ciphertext_out SHALL hold its last value in IDLE and BUSY; it is meaningful only when valid_out=1.

Reset
REQ-014 With rst_n=0 at an edge, SHALL go to IDLE, valid_out=0, round counter=0, ciphertext_out=0 and chain register=0, abandoning any block in progress.
REQ-015 During the reset cycle, ready_in SHALL be 0; ready_in SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-016 Macro AES_CBC_EN defined: SHALL provide iv_in and new_chain_in; the chain value is iv_in if new_chain_in=1 at acceptance, else the chain register; the chain register SHALL load each ciphertext on entry to DONE.
REQ-017 Macro AES_CBC_EN undefined: iv_in, new_chain_in and the chain register SHALL not exist; the core is pure ECB.

Structure
REQ-018 Package aes_pkg SHALL hold the S-box function, the Rcon table, the block/key width constants, an xtime/GF-multiply function and the FSM state enum typedef.
REQ-019 SHALL use one sub-module, aes_round, that is combinational and computes one round plus one key-expansion step, with a final-round flag; aes_iter_core SHALL instantiate ROUNDS_PER_CYCLE copies in a chain via a generate loop.

Verification
REQ-020 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, with valid_out rising exactly CYCLES edges after acceptance; run at ROUNDS_PER_CYCLE=1, 2, 5 and 10.
REQ-021 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; hold ready_out=0 for 7 cycles; ciphertext_out and valid_out must stay stable and ready_in must stay 0.
REQ-022 CBC (SP800-38A F.2.1), key 2b7e...4f3c, iv 000102...0f, new_chain_in=1 then 0:
- pt 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d
- pt ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2
REQ-023 Drive rst_n=0 during BUSY at round counter 4 -> next cycle valid_out=0, ready_in=0; one cycle after release, ready_in=1; a fresh C.1 block then gives the correct result.
REQ-024 Toggle valid_in with differing data throughout BUSY and DONE -> only the first block is accepted, with one result handshake per acceptance.
